instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
IF stage plus IF/ID pipeline register. It sits directly upstream of instruction_decode and feeds it instruc[31:0] and current_PC[9:0].
- Owns the 10-bit word-addressed PC.
- Fetches from a variable-latency instruction memory through a req/ack handshake.
- Redirects on the decode-stage branch decision (pc_sel/jump_address).
- Supports hazard stalls through a one-entry hold buffer.

Parameters:
PC_WIDTH, 10, PC and address width (word addressed, +1 per instruction)
DATA_WIDTH, 32, instruction width
NOP, 32'h0000_0000, bubble word injected on flush/empty

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID contents
pc_sel  in  1  from decode: taken branch for instruction currently in IF/ID
jump_address  in  PC_WIDTH  branch target from decode
imem_req  out  1  fetch request, address valid
imem_addr  out  PC_WIDTH  fetch address (= PC register)
imem_ack  in  1  data valid for imem_addr presented this cycle
imem_rdata  in  DATA_WIDTH  instruction word, valid when imem_ack=1
instruc  out  DATA_WIDTH  IF/ID instruction to decode
current_PC  out  PC_WIDTH  IF/ID: fetch address + 1 (mod 2^PC_WIDTH)
if_valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, immediate): pc=0, state=IDLE, instruc=NOP, current_PC=0, if_valid=0, imem_req=0, hold buffer cleared.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: imem_req=0. Always goes to FETCH on the next edge. Exists only for the first cycle after reset.
  - FETCH: imem_req=1, imem_addr=pc. Both stay stable until ack or redirect.
  - HOLD: imem_req=0. The fetched word is held in the buffer with its address+1.
- Priority at every edge: reset > redirect > stall > normal.
- Redirect condition: pc_sel=1 and if_valid=1 and stall=0.
  - Actions: pc<=jump_address; IF/ID<={NOP, current_PC unchanged}; if_valid<=0; buffer dropped; state<=FETCH.
  - An imem_ack in the same cycle is discarded.
  - pc_sel is ignored when if_valid=0 or stall=1.
- FETCH, ack=1, stall=0: IF/ID<={imem_rdata, pc+1}; if_valid<=1; pc<=pc+1; stay FETCH. Gives back-to-back fetch at 1 instruction/cycle with a zero-wait memory.
- FETCH, ack=1, stall=1: buffer<={imem_rdata, pc+1}; pc<=pc+1; IF/ID unchanged; state<=HOLD.
- FETCH, ack=0, stall=0: IF/ID<=bubble (instruc=NOP, if_valid=0, current_PC unchanged); pc unchanged.
- FETCH, ack=0, stall=1: everything unchanged.
- HOLD, stall=1: unchanged.
- HOLD, stall=0: IF/ID<=buffer; if_valid<=1; state<=FETCH.
- No instruction is lost or duplicated across any stall pattern.
- Latency: instruction visible on instruc 1 cycle after the ack edge (ack at 0 wait states means req cycle N gives the output in cycle N+1).
- Arithmetic: pc+1 wraps modulo 2^PC_WIDTH (1023+1 gives 0). jump_address is used verbatim.
- imem_addr changing (redirect) restarts memory latency. The memory must not ack a stale address.
- All outputs are registered except imem_req and imem_addr, which are decoded from the state and pc registers. There is no combinational path from imem_rdata to any output.

Test Plan:
- Reset then zero-wait memory returning word=addr: after IDLE, instruc is 0,1,2,3 on consecutive cycles; current_PC 1,2,3,4; if_valid=1 from the 2nd cycle after reset release.
- Memory with 2 wait states: imem_addr holds 5 for 3 cycles; if_valid=0 with instruc=NOP for 2 cycles, then instruc=mem[5], current_PC=6.
- stall=1 for 3 cycles arriving with ack at addr 7: IF/ID keeps its old word, imem_req=0 in HOLD. Release gives instruc=mem[7], then mem[8]; nothing skipped or repeated.
- Branch: IF/ID holds addr 10 with pc_sel=1, jump_address=40, plus a simultaneous ack for addr 11. Next cycle: if_valid=0, instruc=NOP, imem_addr=40; mem[11] never appears.
- pc_sel=1 while stall=1, or while if_valid=0: no redirect, pc sequence unchanged.
- Wrap: pc=1023 acked gives current_PC=0 and next imem_addr=0. Asserting reset mid-wait immediately forces outputs to their reset values, then refetch starts from 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage with IF/ID pipeline register: owns the word-addressed PC, fetches over a req/ack
// handshake, redirects on decode branches and parks one fetched word while stalled.
module instruction_fetch #(
    parameter int unsigned         PC_WIDTH   = 10,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP      = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  pc_sel,
    input  logic [PC_WIDTH-1:0]   jump_address,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instruc,
    output logic [PC_WIDTH-1:0]   current_PC,
    output logic                  if_valid
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   cur_pc_q, cur_pc_d;
    logic [PC_WIDTH-1:0]   buf_pc_q, buf_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic                  valid_q, valid_d;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   pc_inc;

    assign pc_inc   = pc_q + PC_WIDTH'(1);
    // A branch decision only counts for a real, non-stalled instruction in IF/ID.
    assign redirect = pc_sel && valid_q && !stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cur_pc_d    = cur_pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (redirect) begin
            // Any ack arriving this cycle belongs to the wrong path and is dropped.
            pc_d        = jump_address;
            instr_d     = NOP;
            valid_d     = 1'b0;
            buf_instr_d = NOP;
            buf_pc_d    = '0;
            state_d     = StFetch;
        end else begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_inc;
                            state_d     = StHold;
                        end else begin
                            instr_d  = imem_rdata;
                            cur_pc_d = pc_inc;
                            valid_d  = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        instr_d  = buf_instr_q;
                        cur_pc_d = buf_pc_q;
                        valid_d  = 1'b1;
                        state_d  = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            cur_pc_q    <= '0;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
            buf_instr_q <= NOP;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cur_pc_q    <= cur_pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign imem_req   = (state_q == StFetch);
    assign imem_addr  = pc_q;
    assign instruc    = instr_q;
    assign current_PC = cur_pc_q;
    assign if_valid   = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vectors, a variable-latency memory responder and a
// queue-based reference model compared at every falling edge, plus hand-computed checkpoints.
module tb_instruction_fetch;

    localparam logic [31:0] NOPW = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, pc_sel, imem_ack, imem_req, if_valid;
    logic [9:0]  jump_address, imem_addr, current_PC;
    logic [31:0] imem_rdata, instruc;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .jump_address (jump_address),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruc      (instruc),
        .current_PC   (current_PC),
        .if_valid     (if_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus settings applied at the next falling edge.
    logic       d_reset = 1'b1;
    logic       d_stall = 1'b0;
    logic       d_sel   = 1'b0;
    logic [9:0] d_jump  = '0;
    int         waits   = 0;

    // Memory responder state.
    int         cnt       = 0;
    logic       last_req  = 1'b0;
    logic       last_ack  = 1'b0;
    logic [9:0] last_addr = '0;

    // Reference model: fetch pointer, a queue for the parked word, and the IF/ID contents.
    typedef struct packed {
        logic [31:0] w;
        logic [9:0]  n;
    } ent_t;

    logic [9:0]  m_pc;
    logic        m_run;
    ent_t        held[$];
    logic [31:0] m_instr;
    logic [9:0]  m_cur;
    logic        m_valid;

    function automatic logic [31:0] word_of(input logic [9:0] a);
        return {22'd0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_run   = 1'b0;
        held.delete();
        m_instr = NOPW;
        m_cur   = '0;
        m_valid = 1'b0;
    endtask

    // Advance the model across the rising edge just passed, using the inputs held over it.
    task automatic model_step();
        ent_t e;
        if (reset) begin
            model_reset();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (pc_sel && m_valid && !stall) begin
            m_pc    = jump_address;
            m_instr = NOPW;
            m_valid = 1'b0;
            held.delete();
        end else if (held.size() != 0) begin
            if (!stall) begin
                e       = held.pop_front();
                m_instr = e.w;
                m_cur   = e.n;
                m_valid = 1'b1;
            end
        end else if (imem_ack) begin
            e.w  = word_of(m_pc);
            e.n  = m_pc + 10'd1;
            m_pc = m_pc + 10'd1;
            if (stall) begin
                held.push_back(e);
            end else begin
                m_instr = e.w;
                m_cur   = e.n;
                m_valid = 1'b1;
            end
        end else if (!stall) begin
            m_instr = NOPW;
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("imem_req",   32'(imem_req),   32'(m_run && held.size() == 0));
        check("imem_addr",  32'(imem_addr),  32'(m_pc));
        check("instruc",    instruc,         m_instr);
        check("current_PC", 32'(current_PC), 32'(m_cur));
        check("if_valid",   32'(if_valid),   32'(m_valid));
    endtask

    // Latency restarts whenever the address changes, the request drops or an ack was given.
    task automatic drive();
        reset        = d_reset;
        stall        = d_stall;
        pc_sel       = d_sel;
        jump_address = d_jump;
        if (imem_req && last_req && !last_ack && imem_addr == last_addr) cnt++;
        else cnt = 0;
        imem_ack   = imem_req && (cnt >= waits);
        imem_rdata = imem_ack ? word_of(imem_addr) : 32'hDEAD_BEEF;
        last_req   = imem_req;
        last_addr  = imem_addr;
        last_ack   = imem_ack;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        compare_all();
        drive();
    endtask

    task automatic exp_ifid(input string tag, input logic [31:0] ins, input logic [9:0] cur,
                            input logic val);
        check({tag, ".instruc"},    instruc,         ins);
        check({tag, ".current_PC"}, 32'(current_PC), 32'(cur));
        check({tag, ".if_valid"},   32'(if_valid),   32'(val));
    endtask

    task automatic exp_fetch(input string tag, input logic req, input logic [9:0] addr);
        check({tag, ".imem_req"},  32'(imem_req),  32'(req));
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
    endtask

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        pc_sel       = 1'b0;
        jump_address = '0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        model_reset();

        tick();
        tick();
        exp_ifid("rst", NOPW, 10'd0, 1'b0);
        exp_fetch("rst", 1'b0, 10'd0);

        // Zero-wait memory: words 0..3 stream out one per cycle.
        d_reset = 1'b0;
        tick();
        exp_fetch("idle", 1'b0, 10'd0);
        tick();
        exp_fetch("f0", 1'b1, 10'd0);
        check("f0.if_valid", 32'(if_valid), 32'd0);
        tick(); exp_ifid("s0", 32'd0, 10'd1, 1'b1);
        tick(); exp_ifid("s1", 32'd1, 10'd2, 1'b1);
        tick(); exp_ifid("s2", 32'd2, 10'd3, 1'b1);
        tick(); exp_ifid("s3", 32'd3, 10'd4, 1'b1);

        // Two wait states on address 5.
        waits = 2;
        tick(); exp_fetch("w0", 1'b1, 10'd5); exp_ifid("w0", 32'd4, 10'd5, 1'b1);
        tick(); exp_fetch("w1", 1'b1, 10'd5); exp_ifid("w1", NOPW, 10'd5, 1'b0);
        tick(); exp_fetch("w2", 1'b1, 10'd5); exp_ifid("w2", NOPW, 10'd5, 1'b0);
        waits = 0;
        tick(); exp_ifid("w3", 32'd5, 10'd6, 1'b1);

        // Three-cycle stall arriving together with the ack for address 7.
        d_stall = 1'b1;
        tick(); exp_fetch("h0", 1'b1, 10'd7); exp_ifid("h0", 32'd6, 10'd7, 1'b1);
        tick(); exp_fetch("h1", 1'b0, 10'd8); exp_ifid("h1", 32'd6, 10'd7, 1'b1);
        tick(); exp_fetch("h2", 1'b0, 10'd8); exp_ifid("h2", 32'd6, 10'd7, 1'b1);
        d_stall = 1'b0;
        tick(); exp_fetch("h3", 1'b0, 10'd8);
        tick(); exp_ifid("h4", 32'd7, 10'd8, 1'b1); exp_fetch("h4", 1'b1, 10'd8);
        tick(); exp_ifid("h5", 32'd8, 10'd9, 1'b1);

        // Taken branch for address 10 while the ack for address 11 arrives.
        tick(); exp_ifid("b0", 32'd9, 10'd10, 1'b1);
        d_sel  = 1'b1;
        d_jump = 10'd40;
        tick(); exp_ifid("b1", 32'd10, 10'd11, 1'b1); exp_fetch("b1", 1'b1, 10'd11);
        d_sel = 1'b0;
        tick(); exp_ifid("b2", NOPW, 10'd11, 1'b0); exp_fetch("b2", 1'b1, 10'd40);
        tick(); exp_ifid("b3", 32'd40, 10'd41, 1'b1);

        // pc_sel ignored while stalled.
        d_stall = 1'b1;
        d_sel   = 1'b1;
        d_jump  = 10'd100;
        tick(); exp_ifid("ps0", 32'd41, 10'd42, 1'b1);
        d_stall = 1'b0;
        d_sel   = 1'b0;
        tick(); exp_fetch("ps1", 1'b0, 10'd43);
        waits = 1;
        tick(); exp_ifid("ps2", 32'd42, 10'd43, 1'b1); exp_fetch("ps2", 1'b1, 10'd43);

        // pc_sel ignored while IF/ID holds a bubble.
        d_sel = 1'b1;
        tick(); exp_ifid("pv0", NOPW, 10'd43, 1'b0);
        d_sel = 1'b0;
        waits = 0;
        tick(); exp_ifid("pv1", 32'd43, 10'd44, 1'b1); exp_fetch("pv1", 1'b1, 10'd44);

        // Redirect near the top of the address space, then wrap.
        d_sel  = 1'b1;
        d_jump = 10'd1022;
        tick(); exp_ifid("wr0", 32'd44, 10'd45, 1'b1);
        d_sel = 1'b0;
        tick(); exp_fetch("wr1", 1'b1, 10'd1022); exp_ifid("wr1", NOPW, 10'd45, 1'b0);
        tick(); exp_ifid("wr2", 32'd1022, 10'd1023, 1'b1);
        tick(); exp_ifid("wr3", 32'd1023, 10'd0, 1'b1); exp_fetch("wr3", 1'b1, 10'd0);

        // Reset asserted in the middle of a memory wait.
        waits = 3;
        tick(); exp_ifid("rm0", 32'd0, 10'd1, 1'b1);
        tick(); exp_ifid("rm1", NOPW, 10'd1, 1'b0); exp_fetch("rm1", 1'b1, 10'd1);
        #2;
        reset   = 1'b1;
        d_reset = 1'b1;
        #1;
        exp_ifid("rm2", NOPW, 10'd0, 1'b0);
        exp_fetch("rm2", 1'b0, 10'd0);
        tick();
        tick();
        d_reset = 1'b0;
        waits   = 0;
        tick(); exp_fetch("rf0", 1'b0, 10'd0);
        tick(); exp_fetch("rf1", 1'b1, 10'd0);
        tick(); exp_ifid("rf2", 32'd0, 10'd1, 1'b1);

        // Mixed stall / branch / latency patterns checked against the model only.
        for (int i = 0; i < 300; i++) begin
            d_stall = (i % 7 == 3) || (i % 7 == 4) || (i % 13 == 0);
            d_sel   = (i % 11 == 5) || (i % 17 == 2);
            d_jump  = 10'((i * 37 + 1000) % 1024);
            waits   = (i / 50) % 3;
            tick();
        end
        d_stall = 1'b0;
        d_sel   = 1'b0;
        waits   = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
